// File: rtl/dcache_controller.sv
// Write-back, write-allocate controller for a 2-way, 16-set, 256-bit-line data cache.
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss/write-back counters.
module dcache_controller #(
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_write_i,
  input  logic [31:0]         cpu_addr_i,
  input  logic [31:0]         cpu_data_i,
  output logic [31:0]         cpu_data_o,
  output logic                cpu_stall_o,
  output logic [IDX_W-1:0]    sram_addr_o,
  output logic [TAG_W+1:0]    sram_tag_o,
  output logic [LINE_W-1:0]   sram_data_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  input  logic [TAG_W+1:0]    sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  input  logic                sram_hit_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [31:0]         mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         wb_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

  state_t              state;
  logic [LINE_W-1:0]   line_buf;
  logic                mem_enable_q, mem_write_q;
  logic [31:0]         mem_addr_q;
  logic                relookup;

  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    idx;
  logic [2:0]          word;
  logic                lookup, hit, miss, victim_dirty;
  logic [LINE_W-1:0]   merged;
  logic                unused_addr_bits;

  assign tag              = cpu_addr_i[31:32-TAG_W];
  assign idx              = cpu_addr_i[IDX_W+4:5];
  assign word             = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign lookup       = (state == IDLE) && cpu_req_i;
  assign hit          = lookup && sram_hit_i;
  assign miss         = lookup && !sram_hit_i;
  assign victim_dirty = sram_tag_i[TAG_W+1] && sram_tag_i[TAG_W];

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = (state == WRITEBACK) ? line_buf : '0;

  always_comb begin
    merged = sram_data_i;
    merged[{word, 5'b0} +: 32] = cpu_data_i;
  end

  // Lookup-side outputs are combinational so hits complete with zero stall;
  // they are forced low while reset is held so a live request cannot leak out.
  always_comb begin
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    if (!rst_i) begin
      if (cpu_req_i) sram_addr_o = idx;
      sram_enable_o = (state == IDLE) ? cpu_req_i : 1'b1;
      cpu_stall_o   = (state != IDLE) || miss;
      if (hit && !cpu_write_i) cpu_data_o = sram_data_i[{word, 5'b0} +: 32];
      if (hit && cpu_write_i) begin
        sram_write_o = 1'b1;
        sram_tag_o   = {2'b11, tag};
        sram_data_o  = merged;
      end
      if (state == UPDATE) begin
        sram_write_o = 1'b1;
        sram_tag_o   = {2'b10, tag};
        sram_data_o  = line_buf;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      line_buf     <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      relookup     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          relookup <= 1'b0;
          if (miss) begin
            line_buf     <= sram_data_i;
            mem_enable_q <= 1'b1;
            if (victim_dirty) begin
              state       <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {sram_tag_i[TAG_W-1:0], idx, 5'b0};
            end else begin
              state       <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {tag, idx, 5'b0};
            end
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          state       <= REFILL;
          mem_write_q <= 1'b0;
          mem_addr_q  <= {tag, idx, 5'b0};
        end
        REFILL: if (mem_ack_i) begin
          state        <= UPDATE;
          line_buf     <= mem_data_i;
          mem_enable_q <= 1'b0;
          mem_addr_q   <= '0;
        end
        UPDATE: begin
          state    <= IDLE;
          relookup <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // The hit that follows UPDATE is the tail of a miss, not a new hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (hit && !relookup && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state == WRITEBACK && mem_ack_i && wb_cnt_o != '1) wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule
